// File: rtl/imm_gen_arbiter_pkg.sv
// Shared decode definitions: opcode encodings, default tag width and a
// 12-bit sign-extension helper used by the immediate generator.
package imm_gen_arbiter_pkg;

  localparam int OPCODE_WIDTH  = 7;
  localparam int TAG_W_DEFAULT = 6;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    R_type      = 7'b0110011,
    I_type_load = 7'b0000011,
    I_type_arth = 7'b0010011,
    S_type      = 7'b0100011,
    SB_type     = 7'b1100011
  } opcode_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imm_gen_arbiter_imm_generator.sv
// Combinational immediate generator: decodes the opcode and produces the
// sign-extended immediate; R-type and unknown opcodes yield zero.
module imm_gen_arbiter_imm_generator
  import imm_gen_arbiter_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Opcode decode and immediate field assembly
  always_comb begin
    imm = '0;
    case (instr[OPCODE_WIDTH-1:0])
      R_type:                   imm = '0;
      I_type_load, I_type_arth: imm = sext12(instr[31:20]);
      S_type:                   imm = sext12({instr[31:25], instr[11:7]});
      SB_type:                  imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_arbiter.sv
// Two-lane round-robin arbiter in front of a shared immediate generator.
// The granted lane's result lands in a one-entry output buffer; flush drops
// the buffered entry and anything accepted in the same cycle.
module imm_gen_arbiter
  import imm_gen_arbiter_pkg::*;
#(
  parameter int TAG_W     = TAG_W_DEFAULT,
  parameter int NUM_LANES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_LANES-1:0]            req_valid,
  input  logic [NUM_LANES-1:0][31:0]      req_instr,
  input  logic [NUM_LANES-1:0][TAG_W-1:0] req_tag,
  output logic [NUM_LANES-1:0]            req_ready,
  output logic                            imm_valid,
  input  logic                            imm_ready,
  output logic [31:0]                     imm_value,
  output logic                            imm_lane,
  output logic [TAG_W-1:0]                imm_tag
);

  if (NUM_LANES != 2) begin : g_lane_check
    $error("imm_gen_arbiter supports exactly two lanes");
  end

  logic             buf_valid, buf_valid_next;
  logic             last_grant, last_grant_next;
  logic [31:0]      buf_value;
  logic             buf_lane;
  logic [TAG_W-1:0] buf_tag;

  logic             can_accept;
  logic [1:0]       grant;
  logic             grant_lane;
  logic             transfer;
  logic             load;
  logic [31:0]      gen_imm;

  assign can_accept = !buf_valid || imm_ready || flush;

  // Round-robin grant; nothing is granted during reset
  always_comb begin
    grant = 2'b00;
    if (!reset && can_accept) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready  = grant;
  assign grant_lane = grant[1];
  assign transfer   = |(grant & req_valid);

  imm_gen_arbiter_imm_generator u_imm_generator (
    .instr (req_instr[grant_lane]),
    .imm   (gen_imm)
  );

  // Next control state: flush beats load, load beats pop
  always_comb begin
    buf_valid_next  = buf_valid;
    last_grant_next = last_grant;
    load            = 1'b0;
    if (transfer) last_grant_next = grant_lane;
    if (flush) begin
      buf_valid_next = 1'b0;
    end else if (transfer) begin
      buf_valid_next = 1'b1;
      load           = 1'b1;
    end else if (imm_ready) begin
      buf_valid_next = 1'b0;
    end
  end

  // Control state and output buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid  <= 1'b0;
      last_grant <= 1'b1;
      buf_value  <= '0;
      buf_lane   <= 1'b0;
      buf_tag    <= '0;
    end else begin
      buf_valid  <= buf_valid_next;
      last_grant <= last_grant_next;
      if (load) begin
        buf_value <= gen_imm;
        buf_lane  <= grant_lane;
        buf_tag   <= req_tag[grant_lane];
      end
    end
  end

  assign imm_valid = buf_valid;
  assign imm_value = buf_value;
  assign imm_lane  = buf_lane;
  assign imm_tag   = buf_tag;

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Scoreboard bench for imm_gen_arbiter: a driver walks a directed vector
// table, checks grants and buffer valid, and queues the expected results;
// a monitor pops and compares whenever the buffer is drained or dropped.
module tb_imm_gen_arbiter;

  localparam int TAG_W = 6;

  localparam logic [31:0] I_LD24   = 32'h01802583;
  localparam logic [31:0] I_LDFFC  = 32'hFFC00003;
  localparam logic [31:0] I_AR7FF  = 32'h7FF00013;
  localparam logic [31:0] S44      = 32'h02000623;
  localparam logic [31:0] SB78     = 32'h078004E3;
  localparam logic [31:0] SBFE0    = 32'hFE0006E3;
  localparam logic [31:0] R66      = 32'h04200033;
  localparam logic [31:0] UNK      = 32'h1230007F;

  logic                        clk;
  logic                        reset;
  logic                        flush;
  logic [1:0]                  req_valid;
  logic [1:0][31:0]            req_instr;
  logic [1:0][TAG_W-1:0]       req_tag;
  logic [1:0]                  req_ready;
  logic                        imm_valid;
  logic                        imm_ready;
  logic [31:0]                 imm_value;
  logic                        imm_lane;
  logic [TAG_W-1:0]            imm_tag;

  typedef struct {
    logic             rst;
    logic             fl;
    logic [1:0]       valid;
    logic [31:0]      i0;
    logic [TAG_W-1:0] t0;
    logic [31:0]      i1;
    logic [TAG_W-1:0] t1;
    logic             ird;
    logic [1:0]       exp_rdy;
    logic             exp_v;
    logic [31:0]      exp_imm;
  } vec_t;

  typedef struct {
    logic [31:0]      value;
    logic             lane;
    logic [TAG_W-1:0] tag;
  } res_t;

  vec_t vecs[$];
  res_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  imm_gen_arbiter #(.TAG_W(TAG_W), .NUM_LANES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_instr (req_instr),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .imm_valid (imm_valid),
    .imm_ready (imm_ready),
    .imm_value (imm_value),
    .imm_lane  (imm_lane),
    .imm_tag   (imm_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic fl, input logic [1:0] valid,
                     input logic [31:0] i0, input logic [TAG_W-1:0] t0,
                     input logic [31:0] i1, input logic [TAG_W-1:0] t1,
                     input logic ird, input logic [1:0] exp_rdy,
                     input logic exp_v, input logic [31:0] exp_imm);
    vec_t v;
    v.rst = rst; v.fl = fl; v.valid = valid;
    v.i0 = i0; v.t0 = t0; v.i1 = i1; v.t1 = t1;
    v.ird = ird; v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.exp_imm = exp_imm;
    vecs.push_back(v);
  endtask

  // Monitor: compare the buffered result whenever it leaves the buffer
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (imm_valid === 1'b1 && (imm_ready || flush || reset)) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {31'd0, imm_valid}, 32'd0);
        end else begin
          res_t r;
          r = sb.pop_front();
          chk("imm_value", imm_value, r.value);
          chk("imm_lane", {31'd0, imm_lane}, {31'd0, r.lane});
          chk("imm_tag", {26'd0, imm_tag}, {26'd0, r.tag});
        end
      end
    end
  end

  // Driver
  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0; req_instr = '0; req_tag = '0; imm_ready = 1'b0;

    //   rst fl valid  i0       t0  i1      t1  ird rdy    v  imm
    add(1, 0, 2'b11, I_LD24,  1,  SB78,   2,  1, 2'b00, 0, 32'd0);
    add(0, 0, 2'b01, I_LD24,  3,  0,      0,  0, 2'b01, 0, 32'd24);
    add(0, 0, 2'b00, 0,       0,  0,      0,  1, 2'b00, 1, 32'd0);
    add(0, 0, 2'b10, 0,       0,  I_AR7FF,7,  1, 2'b10, 0, 32'd2047);
    add(0, 0, 2'b11, S44,     10, SB78,   20, 1, 2'b01, 1, 32'd44);
    add(0, 0, 2'b11, S44,     11, SB78,   21, 1, 2'b10, 1, 32'd2152);
    add(0, 0, 2'b11, S44,     12, SB78,   22, 1, 2'b01, 1, 32'd44);
    add(0, 0, 2'b11, S44,     13, SB78,   23, 1, 2'b10, 1, 32'd2152);
    add(0, 0, 2'b10, 0,       0,  SBFE0,  5,  1, 2'b10, 1, 32'hFFFFFFEC);
    add(0, 0, 2'b01, I_LD24,  6,  0,      0,  0, 2'b00, 1, 32'd0);
    add(0, 0, 2'b01, I_LD24,  6,  0,      0,  0, 2'b00, 1, 32'd0);
    add(0, 0, 2'b01, I_LD24,  6,  0,      0,  0, 2'b00, 1, 32'd0);
    add(0, 0, 2'b01, I_LD24,  6,  0,      0,  1, 2'b01, 1, 32'd24);
    add(0, 0, 2'b01, I_LDFFC, 9,  0,      0,  1, 2'b01, 1, 32'hFFFFFFFC);
    add(0, 1, 2'b01, I_LD24,  12, 0,      0,  0, 2'b01, 1, 32'd24);
    add(0, 0, 2'b11, R66,     30, R66,    31, 1, 2'b10, 0, 32'd0);
    add(0, 0, 2'b11, R66,     32, R66,    33, 1, 2'b01, 1, 32'd0);
    add(1, 0, 2'b11, S44,     34, SB78,   35, 0, 2'b00, 1, 32'd0);
    add(0, 0, 2'b11, S44,     40, SB78,   41, 0, 2'b01, 0, 32'd44);
    add(0, 0, 2'b11, UNK,     42, SBFE0,  43, 0, 2'b00, 1, 32'd0);
    add(0, 0, 2'b11, UNK,     42, SBFE0,  43, 1, 2'b10, 1, 32'hFFFFFFEC);
    add(0, 0, 2'b01, UNK,     44, 0,      0,  1, 2'b01, 1, 32'd0);
    add(0, 1, 2'b00, 0,       0,  0,      0,  0, 2'b00, 1, 32'd0);
    add(0, 0, 2'b00, 0,       0,  0,      0,  0, 2'b00, 0, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      reset        = vecs[k].rst;
      flush        = vecs[k].fl;
      req_valid    = vecs[k].valid;
      req_instr[0] = vecs[k].i0;
      req_instr[1] = vecs[k].i1;
      req_tag[0]   = vecs[k].t0;
      req_tag[1]   = vecs[k].t1;
      imm_ready    = vecs[k].ird;
      @(negedge clk);
      chk($sformatf("req_ready[v%0d]", k), {30'd0, req_ready}, {30'd0, vecs[k].exp_rdy});
      chk($sformatf("imm_valid[v%0d]", k), {31'd0, imm_valid}, {31'd0, vecs[k].exp_v});
      if (vecs[k].exp_rdy != 2'b00 && !vecs[k].fl && !vecs[k].rst) begin
        res_t r;
        r.value = vecs[k].exp_imm;
        r.lane  = vecs[k].exp_rdy[1];
        r.tag   = vecs[k].exp_rdy[1] ? vecs[k].t1 : vecs[k].t0;
        sb.push_back(r);
      end
      @(posedge clk);
      #1;
    end

    reset = 1'b0; flush = 1'b0; req_valid = '0; imm_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("imm_value_known", {31'd0, $isunknown(imm_value)}, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_arbiter.md
Name: imm_gen_arbiter

Overview:
- Shares one IMM_GENERATOR instance between the two decode lanes of the dual-issue ID stage.
- Each lane presents an instruction word plus a ROB tag with a valid/ready handshake; the block grants one lane per cycle, round-robin.
- The granted instruction goes through the combinational generator, and the result is registered into a one-entry output buffer for the rename/dispatch consumer.
- A flush input discards the buffered result on branch mispredict.

Parameters:
- TAG_W, 6, width of the ROB tag carried alongside each request.
- NUM_LANES, 2, number of requesting decode lanes; the design is fixed at 2, and any other value is a compile-time error.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict flush; drops the buffered result.
- req_valid  in  2  per-lane request valid.
- req_instr  in  2x32  per-lane instruction word.
- req_tag  in  2xTAG_W  per-lane ROB tag.
- req_ready  out  2  per-lane grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- imm_valid  out  1  output buffer holds a result.
- imm_ready  in  1  consumer accepts the result.
- imm_value  out  32  generated immediate (sign-extended).
- imm_lane  out  1  lane index that produced the result.
- imm_tag  out  TAG_W  ROB tag of the result.

Behaviour:
- Reset, synchronous and active-high:
  - imm_valid=0, imm_value=0, imm_lane=0, imm_tag=0.
  - last_grant=1, so lane 0 wins first.
  - req_ready=0 while reset is high.
- Buffer can_accept = !imm_valid | imm_ready | flush.
- Grant, combinational:
  - If can_accept=0: req_ready=00.
  - Else if exactly one lane is valid: grant that lane.
  - Else if both lanes are valid: grant lane !last_grant.
  - Else: req_ready=00.
  - At most one req_ready bit is high in any cycle.
  - req_ready depends only on req_valid, imm_valid, imm_ready, flush and last_grant.
- last_grant updates to the granted lane only on a completed transfer; it holds otherwise.
- Datapath: the mux selects the granted lane's instr into IMM_GENERATOR. On transfer, the next cycle has imm_valid=1 with the generator output, lane and tag. Latency is 1 cycle, request accept to imm_valid.
- Immediate rules (generator contract, checked by the bench):
  - R_type: 0.
  - I_type_load / I_type_arth: sext(instr[31:20]).
  - S_type: sext({instr[31:25],instr[11:7]}).
  - SB_type: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Unknown opcode: 0.
- Output hold: while imm_valid=1 and imm_ready=0, imm_value/imm_lane/imm_tag stay stable and no grant is given.
- Simultaneous pop and push (imm_ready=1 with a new transfer): the buffer reloads in the same edge with no bubble, giving one result per cycle sustained.
- Pop without push: imm_valid goes to 0. Data outputs keep their last value; they are don't-care but must not be X.
- Flush:
  - flush=1 clears imm_valid next edge regardless of imm_ready.
  - A request granted in a flush cycle is also discarded. Grants still occur and last_grant still advances, so upstream sees a normal handshake.
  - Flush has priority over load.
- Reset mid-operation: the buffered result is dropped, last_grant returns to 1, and no transfer completes in the reset cycle.
- No state machine beyond the buffer valid bit and last_grant (2 bits of control state).

Decomposition:
- Shared package (existing decode package): opcode enum (R_type, I_type_load, I_type_arth, S_type, SB_type), `OPCODE_WIDTH, TAG_W default.
- Sub-module: the existing IMM_GENERATOR, instantiated once, unchanged.
- Arbitration logic is small and stays inline; no separate rr_arbiter module.

Test Plan:
- Lane 0 only: I_type_load with [31:20]=24, [11:7]=11, tag 3 -> req_ready=01 same cycle. Next cycle: imm_valid=1, imm_value=24, imm_lane=0, imm_tag=3.
- Both lanes every cycle, imm_ready=1:
  - Lane 0 sends S_type {[31:25]=0000001,[11:7]=01100}; lane 1 sends SB_type [31:20]=0x078, [11:7]=01001.
  - Grants alternate 0,1,0,1 starting with lane 0.
  - Outputs alternate 44 and 2152, one per cycle, no bubbles.
- Backpressure:
  - Lane 1 sends SB_type [31:20]=0xFE0, [11:7]=01101; imm_ready=0 for 3 cycles.
  - imm_value=-20 (0xFFFFFFEC) stays stable and req_ready=00 throughout.
  - Raising imm_ready pops the result and grants the next request in the same cycle.
- Flush:
  - Buffer holds I_type_load sext(0xFFC)=-4; assert flush with lane 0 valid.
  - Next cycle imm_valid=0, and the lane-0 request counts as consumed.
  - last_grant=0, so the next contention goes to lane 1.
- Reset mid-stream: reset during sustained traffic with a valid buffered result -> next cycle imm_valid=0, req_ready=00; after release, the first contention is granted to lane 0.
- R_type from both lanes with [31:20]=66 -> imm_value=0 for each result; tags are preserved in grant order.
